// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder: WIDTH/SEG segments, one register stage each,
// valid/ready on both ends. Define CLA_PIPE_OVF_EN to add the signed-overflow output.
module cla_pipe_adder #(
  parameter int WIDTH = 128,
  parameter int SEG   = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co
`ifdef CLA_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int NSEG = WIDTH / SEG;
  localparam int L    = NSEG - 1;

  // Kogge-Stone prefix over one segment; bit 0 generate absorbs the carry in,
  // so g[i] ends up as the carry out of bit i.
  function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] x, input logic [SEG-1:0] y,
                                           input logic cin);
    logic [SEG-1:0] p, g, gp, cv;
    p    = x ^ y;
    g    = x & y;
    gp   = p;
    g[0] = g[0] | (p[0] & cin);
    for (int d = 1; d < SEG; d = d * 2)
      for (int i = SEG - 1; i >= d; i--) begin
        g[i]  = g[i] | (gp[i] & g[i-d]);
        gp[i] = gp[i] & gp[i-d];
      end
    cv[0] = cin;
    for (int i = 1; i < SEG; i++) cv[i] = g[i-1];
    return {g[SEG-1], p ^ cv};
  endfunction

  logic             adv;
  logic [NSEG-1:0]  vld_pipe, cy_q, c_in, v_in, seg_co;
  logic [WIDTH-1:0] a_q [NSEG];
  logic [WIDTH-1:0] b_q [NSEG];
  logic [WIDTH-1:0] s_q [NSEG];
  logic [WIDTH-1:0] a_in [NSEG];
  logic [WIDTH-1:0] b_in [NSEG];
  logic [WIDTH-1:0] s_in [NSEG];
  logic [WIDTH-1:0] s_nx [NSEG];
  logic [SEG-1:0]   seg_s [NSEG];

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // Operands travel shifted down so the segment being added always sits in
  // bits [SEG-1:0]; finished sum segments accumulate in place.
  for (genvar k = 0; k < NSEG; k++) begin : g_stg
    if (k == 0) begin : g_src
      assign a_in[k] = a;
      assign b_in[k] = b;
      assign s_in[k] = '0;
      assign c_in[k] = ci;
      assign v_in[k] = in_valid;
    end else begin : g_src
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign s_in[k] = s_q[k-1];
      assign c_in[k] = cy_q[k-1];
      assign v_in[k] = vld_pipe[k-1];
    end
    assign {seg_co[k], seg_s[k]} = cla_seg(a_in[k][SEG-1:0], b_in[k][SEG-1:0], c_in[k]);
    assign s_nx[k] = s_in[k] | (WIDTH'(seg_s[k]) << (k * SEG));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      cy_q     <= '0;
      for (int k = 0; k < NSEG; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (adv) begin
      vld_pipe <= v_in;
      cy_q     <= seg_co;
      for (int k = 0; k < NSEG; k++) begin
        a_q[k] <= a_in[k] >> SEG;
        b_q[k] <= b_in[k] >> SEG;
        s_q[k] <= s_nx[k];
      end
    end
  end

  assign out_valid = vld_pipe[L];
  assign s         = s_q[L];
  assign co        = cy_q[L];

`ifdef CLA_PIPE_OVF_EN
  // The operand sign bits reach bit SEG-1 of the last stage's skewed operands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ovf <= 1'b0;
    else if (adv)
      ovf <= (a_in[L][SEG-1] == b_in[L][SEG-1]) & (seg_s[L][SEG-1] != a_in[L][SEG-1]);
  end
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder (WIDTH=128, SEG=32): vector table plus scoreboard,
// hand sequences for latency, back-to-back, stall, bubbles, reset, random traffic.
module tb_cla_pipe_adder;
  localparam int W    = 128;
  localparam int NSEG = 4;

  logic         clk = 1'b0, reset_n = 1'b0;
  logic         in_valid = 1'b0, out_ready = 1'b1, ci = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         in_ready, out_valid, co;
  logic [W-1:0] s;
`ifdef CLA_PIPE_OVF_EN
  logic         ovf;
`endif

  cla_pipe_adder #(.WIDTH(W), .SEG(32)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .co(co)
`ifdef CLA_PIPE_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] s; logic co; logic ovf; } res_t;
  typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic ci;
                   logic [W-1:0] s; logic co; logic ovf; } vec_t;

  res_t sb[$];
  int   ret_log[$];
  int   errors = 0, checks = 0, cyc = 0;
  res_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    res_t r;
    logic [W:0] t;
    t     = {1'b0, x} + {1'b0, y} + (W+1)'(c);
    r.s   = t[W-1:0];
    r.co  = t[W];
    r.ovf = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return r;
  endfunction

  // Retire monitor: every accepted result is compared in order.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      ret_log.push_back(cyc);
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_out: got s=%h with nothing pending, required no output", s);
      end else begin
        mon_e = sb.pop_front();
        check("result_s", s, mon_e.s);
        check("result_co", W'(co), W'(mon_e.co));
`ifdef CLA_PIPE_OVF_EN
        check("result_ovf", W'(ovf), W'(mon_e.ovf));
`endif
      end
    end
  end

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic tci,
                      input res_t e);
    int n = 0;
    a = ta; b = tb2; ci = tci; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin n++; @(negedge clk); end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready got 0 for 50 cycles, required 1");
    end else sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin @(posedge clk); n++; end
    #1;
    check(name, W'(sb.size()), W'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  vec_t tbl[10];
  res_t e;
  int   lat, n, issued, pend;
  logic [W-1:0] ra, rb;
  logic rci;
  logic [3:0] pat;

  initial begin
    tbl[0] = '{a:'0, b:'0, ci:1'b0, s:'0, co:1'b0, ovf:1'b0};
    tbl[1] = '{a:{W{1'b1}}, b:'0, ci:1'b1, s:'0, co:1'b1, ovf:1'b0};
    tbl[2] = '{a:{W{1'b1}}, b:{W{1'b1}}, ci:1'b1, s:{W{1'b1}}, co:1'b1, ovf:1'b0};
    tbl[3] = '{a:128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, b:128'h1, ci:1'b0,
               s:128'h80000000_00000000_00000000_00000000, co:1'b0, ovf:1'b1};
    tbl[4] = '{a:128'h80000000_00000000_00000000_00000000,
               b:128'h80000000_00000000_00000000_00000000, ci:1'b0, s:'0, co:1'b1, ovf:1'b1};
    tbl[5] = '{a:128'hFFFFFFFF, b:128'h1, ci:1'b0, s:128'h1_00000000, co:1'b0, ovf:1'b0};
    tbl[6] = '{a:128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, b:'0, ci:1'b1,
               s:128'h00000001_00000000_00000000_00000000, co:1'b0, ovf:1'b0};
    tbl[7] = '{a:128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978,
               b:128'h11111111_11111111_11111111_11111111, ci:1'b0,
               s:128'h23456789_ABCDF001_202F3E4D_5C6B7A89, co:1'b0, ovf:1'b0};
    tbl[8] = '{a:128'hFFFFFFFF_00000000_FFFFFFFF_00000001,
               b:128'h00000001_00000000_00000001_FFFFFFFF, ci:1'b0,
               s:128'h00000000_00000001_00000001_00000000, co:1'b1, ovf:1'b0};
    tbl[9] = '{a:128'h40000000_00000000_00000000_00000000,
               b:128'h40000000_00000000_00000000_00000000, ci:1'b0,
               s:128'h80000000_00000000_00000000_00000000, co:1'b0, ovf:1'b1};

    // Reset state (out_ready low so in_ready depends on out_valid alone)
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", W'(out_valid), W'(0));
    check("reset_s", s, '0);
    check("reset_co", W'(co), W'(0));
    check("reset_in_ready", W'(in_ready), W'(1));
`ifdef CLA_PIPE_OVF_EN
    check("reset_ovf", W'(ovf), W'(0));
`endif
    reset_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Latency on an empty pipe
    send(128'd5, 128'd7, 1'b0, model(128'd5, 128'd7, 1'b0));
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("latency", W'(lat), W'(NSEG));
    wait_drain("drain_latency");

    // Vector table
    for (int i = 0; i < 10; i++) begin
      e.s = tbl[i].s; e.co = tbl[i].co; e.ovf = tbl[i].ovf;
      send(tbl[i].a, tbl[i].b, tbl[i].ci, e);
    end
    idle();
    wait_drain("drain_table");

    // Back-to-back: 16 ops, results on 16 consecutive cycles
    ret_log.delete();
    for (int i = 0; i < 16; i++) begin
      e.s = W'((2 * i) % 256) << 120; e.co = (i >= 128); e.ovf = 1'b0;
      send(W'(i) << 120, W'(i) << 120, 1'b0, e);
    end
    idle();
    wait_drain("drain_b2b");
    check("b2b_count", W'(ret_log.size()), W'(16));
    if (ret_log.size() == 16) check("b2b_span", W'(ret_log[15] - ret_log[0]), W'(15));

    // Stall with a full pipe: carries sit between segments while frozen
    out_ready = 1'b0;
    ret_log.delete();
    for (int i = 0; i < 4; i++) begin
      ra = {4{32'hFFFFFFFF - 32'(i)}}; rb = W'(i + 1); rci = i[0];
      send(ra, rb, rci, model(ra, rb, rci));
    end
    in_valid = 1'b0;
    e = model({4{32'hFFFFFFFF}}, W'(1), 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", W'(in_ready), W'(0));
      check("stall_out_valid", W'(out_valid), W'(1));
      check("stall_s", s, e.s);
      check("stall_co", W'(co), W'(e.co));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain("drain_stall");
    check("stall_count", W'(ret_log.size()), W'(4));

    // Bubbles: op, gap, op, gap -> out_valid 1,0,1,0 four cycles later
    send(128'd1, 128'd2, 1'b0, model(128'd1, 128'd2, 1'b0));
    idle();
    send(128'd3, 128'd4, 1'b1, model(128'd3, 128'd4, 1'b1));
    idle();
    pat = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bubble_pattern", W'(out_valid), W'(pat[i]));
    end
    wait_drain("drain_bubble");

    // Reset with three ops in flight
    for (int i = 0; i < 3; i++) send(W'(i + 9), W'(i), 1'b1, model(W'(i + 9), W'(i), 1'b1));
    in_valid = 1'b0;
    reset_n = 1'b0;
    sb.delete();
    #2;
    check("midreset_out_valid", W'(out_valid), W'(0));
    check("midreset_s", s, '0);
    check("midreset_co", W'(co), W'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_reset_valid", W'(out_valid), W'(0));
    end
    @(posedge clk); #1;

    // Random traffic with random backpressure
    issued = 0; pend = 0; n = 0;
    while (issued < 10000 && n < 60000) begin
      if (pend == 0 && $urandom_range(0, 4) != 0) begin
        ra = {$urandom, $urandom, $urandom, $urandom};
        rb = {$urandom, $urandom, $urandom, $urandom};
        if ($urandom_range(0, 7) == 0) ra = {W{1'b1}};
        if ($urandom_range(0, 7) == 0) rb = ~ra;
        rci = 1'($urandom_range(0, 1));
        pend = 1;
      end
      a = ra; b = rb; ci = rci; in_valid = (pend != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (pend != 0 && in_ready) begin
        sb.push_back(model(ra, rb, rci));
        pend = 0;
        issued++;
      end
      @(posedge clk); #1;
      n++;
    end
    check("random_issued", W'(issued), W'(10000));
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain("drain_random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
